// File: rtl/id_scoreboard.sv
// Register-dependency scoreboard for the decode stage: per-register producer age/latency tracking,
// forwarding selects and load-use style stall. Optional stall counter under ID_SCOREBOARD_STATS_EN.
module id_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int MAXLAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            flush,
  input  logic            src_a_used,
  input  logic [AW-1:0]   src_a_addr,
  input  logic            src_b_used,
  input  logic [AW-1:0]   src_b_addr,
  input  logic            dst_wen,
  input  logic [AW-1:0]   dst_addr,
  input  logic [1:0]      dst_lat,
  output logic            stall,
  output logic            issue_fire,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic [NREG-1:0] busy_mask,
  output logic [31:0]     stall_cycles
);

  logic [NREG-1:0] pend_vec;
  logic [2:0]      age_vec [NREG];
  logic [1:0]      lat_vec [NREG];

  logic       wr_en;
  logic [1:0] wr_lat;

  assign wr_en  = issue_fire & dst_wen & (dst_addr != '0);
  assign wr_lat = (dst_lat == 2'd0 || int'(dst_lat) > MAXLAT) ? 2'(MAXLAT) : dst_lat;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign pend_vec[gi] = 1'b0;
        assign age_vec[gi]  = 3'd0;
        assign lat_vec[gi]  = 2'd0;
      end else begin : g_track
        logic       pend_q, pend_d;
        logic [2:0] age_q, age_d;
        logic [1:0] lat_q, lat_d;

        // Ageing runs regardless of stall; a new issue to the same register replaces the entry.
        always_comb begin
          pend_d = pend_q;
          age_d  = age_q;
          lat_d  = lat_q;
          if (pend_q) begin
            if (age_q == 3'd3) begin
              pend_d = 1'b0;
              age_d  = 3'd0;
            end else begin
              age_d = age_q + 3'd1;
            end
          end
          if (wr_en && dst_addr == AW'(gi)) begin
            pend_d = 1'b1;
            age_d  = 3'd1;
            lat_d  = wr_lat;
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            pend_q <= 1'b0;
            age_q  <= 3'd0;
            lat_q  <= 2'd0;
          end else begin
            pend_q <= pend_d;
            age_q  <= age_d;
            lat_q  <= lat_d;
          end
        end

        assign pend_vec[gi] = pend_q;
        assign age_vec[gi]  = age_q;
        assign lat_vec[gi]  = lat_q;
      end
    end
  endgenerate

  function automatic logic [1:0] sel_of(input logic p, input logic [2:0] a);
    logic [1:0] s;
    s = 2'b00;
    if (p) begin
      case (a)
        3'd1:    s = 2'b11;
        3'd2:    s = 2'b10;
        3'd3:    s = 2'b01;
        default: s = 2'b00;
      endcase
    end
    return s;
  endfunction

  logic       a_pend, b_pend, hazard_a, hazard_b;
  logic [2:0] a_age, b_age;
  logic [1:0] a_lat, b_lat;

  assign a_pend = (src_a_addr != '0) & pend_vec[src_a_addr];
  assign b_pend = (src_b_addr != '0) & pend_vec[src_b_addr];
  assign a_age  = age_vec[src_a_addr];
  assign b_age  = age_vec[src_b_addr];
  assign a_lat  = lat_vec[src_a_addr];
  assign b_lat  = lat_vec[src_b_addr];

  assign hazard_a = src_a_used & a_pend & (a_age < {1'b0, a_lat});
  assign hazard_b = src_b_used & b_pend & (b_age < {1'b0, b_lat});

  assign stall      = ~rst & issue_valid & ~flush & (hazard_a | hazard_b);
  assign issue_fire = issue_valid & ~stall & ~flush;
  assign fwd_a_sel  = rst ? 2'b00 : sel_of(a_pend, a_age);
  assign fwd_b_sel  = rst ? 2'b00 : sel_of(b_pend, b_age);
  assign busy_mask  = pend_vec;

`ifdef ID_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'd0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && wr_en && (dst_lat == 2'd0 || int'(dst_lat) > MAXLAT))
      $error("id_scoreboard: illegal dst_lat %0d clamped to %0d", dst_lat, MAXLAT);
  end
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed-vector bench for id_scoreboard: stimulus pushes hand-computed expectations into a
// queue, a negedge monitor pops and compares the DUT outputs for that cycle.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0, flush = 1'b0;
  logic        src_a_used = 1'b0, src_b_used = 1'b0, dst_wen = 1'b0;
  logic [4:0]  src_a_addr = '0, src_b_addr = '0, dst_addr = '0;
  logic [1:0]  dst_lat = 2'd1;
  logic        stall, issue_fire;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] busy_mask, stall_cycles;

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .flush(flush),
    .src_a_used(src_a_used), .src_a_addr(src_a_addr),
    .src_b_used(src_b_used), .src_b_addr(src_b_addr),
    .dst_wen(dst_wen), .dst_addr(dst_addr), .dst_lat(dst_lat),
    .stall(stall), .issue_fire(issue_fire), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .busy_mask(busy_mask), .stall_cycles(stall_cycles)
  );

  typedef struct {
    string       nm;
    int          es, ef, efa, efb;   // -1 = don't check
    logic [31:0] busy;
    bit          cb;
    logic [31:0] cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  task automatic step(input string nm, input logic r, input logic iv, input logic fl,
                      input logic au, input logic [4:0] aa, input logic bu, input logic [4:0] ba,
                      input logic we, input logic [4:0] da, input logic [1:0] dl,
                      input int es, input int ef, input int efa, input int efb,
                      input logic [31:0] busy, input bit cb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; issue_valid = iv; flush = fl;
    src_a_used = au; src_a_addr = aa; src_b_used = bu; src_b_addr = ba;
    dst_wen = we; dst_addr = da; dst_lat = dl;
    e.nm = nm; e.es = es; e.ef = ef; e.efa = efa; e.efb = efb; e.busy = busy; e.cb = cb;
`ifdef ID_SCOREBOARD_STATS_EN
    e.cyc = 32'(exp_cnt);
`else
    e.cyc = 32'd0;
`endif
    q.push_back(e);
    if (r) exp_cnt = 0;
    else if (es == 1) exp_cnt++;
  endtask

  function automatic void chk(input string nm, input string what, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, what, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.es  >= 0) chk(e.nm, "stall", int'(stall), e.es);
      if (e.ef  >= 0) chk(e.nm, "issue_fire", int'(issue_fire), e.ef);
      if (e.efa >= 0) chk(e.nm, "fwd_a_sel", int'(fwd_a_sel), e.efa);
      if (e.efb >= 0) chk(e.nm, "fwd_b_sel", int'(fwd_b_sel), e.efb);
      if (e.cb) begin
        n_tests++;
        if (busy_mask !== e.busy) begin
          n_fail++;
          $display("FAIL %s.busy_mask: got %h expected %h", e.nm, busy_mask, e.busy);
        end
      end
      n_tests++;
      if (stall_cycles !== e.cyc) begin
        n_fail++;
        $display("FAIL %s.stall_cycles: got %0d expected %0d", e.nm, stall_cycles, e.cyc);
      end
      $display("[TB] %s: stall=%0d fire=%0d fa=%0d fb=%0d busy=%h cyc=%0d",
               e.nm, stall, issue_fire, fwd_a_sel, fwd_b_sel, busy_mask, stall_cycles);
    end
  end

  localparam logic [31:0] B8 = 32'h1 << 8, B9 = 32'h1 << 9, B10 = 32'h1 << 10;
  localparam logic [31:0] B12 = 32'h1 << 12;

  initial begin
    int budget;
    @(posedge clk);
    //   name       rst iv fl au aa  bu ba  we da  dl   es ef fa fb  busy cb
    step("rst1",    1, 1, 0, 1, 8,  0, 0,  1, 8,  1,   0, 1, 0, 0,  0,   1);
    step("rst2",    1, 1, 0, 1, 8,  1, 8,  1, 8,  1,   0, 1, 0, 0,  0,   1);
    // ALU chain on $8
    step("alu_iss", 0, 1, 0, 0, 0,  0, 0,  1, 8,  1,   0, 1, 0, 0,  0,   1);
    step("alu_ex",  0, 1, 0, 1, 8,  0, 0,  0, 0,  1,   0, 1, 3, 0,  B8,  1);
    step("alu_mem", 0, 1, 0, 0, 0,  1, 8,  0, 0,  1,   0, 1, 0, 2,  B8,  1);
    step("alu_wb",  0, 1, 0, 0, 0,  1, 8,  0, 0,  1,   0, 1, 0, 1,  B8,  1);
    step("alu_rf",  0, 1, 0, 0, 0,  1, 8,  0, 0,  1,   0, 1, 0, 0,  0,   1);
    // load-use on $9, lat 2 then lat 3
    step("ld_iss",  0, 1, 0, 0, 0,  0, 0,  1, 9,  2,   0, 1, 0, 0,  0,   1);
    step("ld_use1", 0, 1, 0, 1, 9,  0, 0,  0, 0,  1,   1, 0, 3, 0,  B9,  1);
    step("ld_use2", 0, 1, 0, 1, 9,  0, 0,  0, 0,  1,   0, 1, 2, 0,  B9,  1);
    step("mc_iss",  0, 1, 0, 0, 0,  0, 0,  1, 9,  3,   0, 1, 0, 0,  B9,  1);
    step("mc_use1", 0, 1, 0, 1, 9,  0, 0,  0, 0,  1,   1, 0, 3, 0,  B9,  1);
    step("mc_use2", 0, 1, 0, 1, 9,  0, 0,  0, 0,  1,   1, 0, 2, 0,  B9,  1);
    step("mc_use3", 0, 1, 0, 1, 9,  0, 0,  0, 0,  1,   0, 1, 1, 0,  B9,  1);
    step("mc_done", 0, 0, 0, 0, 0,  0, 0,  0, 0,  1,   0, 0, 0, 0,  0,   1);
    // WAW on $10, then $0 never tracked
    step("waw_1",   0, 1, 0, 0, 0,  0, 0,  1, 10, 3,   0, 1, 0, 0,  0,   1);
    step("waw_2",   0, 1, 0, 0, 0,  0, 0,  1, 10, 1,   0, 1, 0, 0,  B10, 1);
    step("waw_use", 0, 1, 0, 1, 10, 1, 10, 0, 0,  1,   0, 1, 3, 3,  B10, 1);
    step("z_iss",   0, 1, 0, 0, 0,  0, 0,  1, 0,  2,   0, 1, 0, 0,  B10, 1);
    step("z_use",   0, 1, 0, 1, 0,  1, 0,  0, 0,  1,   0, 1, 0, 0,  B10, 1);
    step("z_idle",  0, 0, 0, 1, 0,  1, 0,  0, 0,  1,   0, 0, 0, 0,  0,   1);
    // flush beats stall, flushed instruction writes nothing
    step("fl_iss",  0, 1, 0, 0, 0,  0, 0,  1, 9,  2,   0, 1, 0, 0,  0,   1);
    step("fl_kill", 0, 1, 1, 1, 9,  0, 0,  1, 11, 1,   0, 0, 3, 0,  B9,  1);
    step("fl_chk",  0, 0, 0, 1, 11, 1, 9,  0, 0,  1,   0, 0, 0, 2,  B9,  1);
    step("fl_age3", 0, 0, 0, 0, 0,  1, 9,  0, 0,  1,   0, 0, 0, 1,  B9,  1);
    step("fl_done", 0, 0, 0, 0, 0,  0, 0,  0, 0,  1,   0, 0, 0, 0,  0,   1);
    // src == dst sees the older producer
    step("sd_iss",  0, 1, 0, 0, 0,  0, 0,  1, 12, 2,   0, 1, 0, 0,  0,   1);
    step("sd_st",   0, 1, 0, 1, 12, 0, 0,  1, 12, 1,   1, 0, 3, 0,  B12, 1);
    step("sd_go",   0, 1, 0, 1, 12, 0, 0,  1, 12, 1,   0, 1, 2, 0,  B12, 1);
    step("sd_new",  0, 1, 0, 1, 12, 0, 0,  0, 0,  1,   0, 1, 3, 0,  B12, 1);
    // reset mid-operation drops $13 tracking and clears the counter
    step("mr_iss",  0, 1, 0, 0, 0,  0, 0,  1, 13, 3,   0, 1, 0, 0,  B12, 1);
    step("mr_rst",  1, 1, 0, 1, 13, 0, 0,  0, 0,  1,   0, 1, -1, 0, 0,   0);
    step("mr_use",  0, 1, 0, 1, 13, 0, 0,  0, 0,  1,   0, 1, 0, 0,  0,   1);
    @(posedge clk);
    #1;
    issue_valid = 1'b0; src_a_used = 1'b0; src_b_used = 1'b0; dst_wen = 1'b0;
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
